alu_stim_gen: RTL and testbench

Synthesizable, parametrised ALU stimulus generator: produces a seeded pseudo-random stream of {cmd, in1, in2} transactions on a valid/ready port.
- Corner-value injection: all-zeros/all-ones operands at 1/8 probability each.
- Programmable transaction count with start/done control.
- Sits in front of the ALU under test in on-chip and emulation benches, replacing software-driven stimulus.

---
 rtl/alu1_pkg.sv | 12 +
 rtl/alu_stim_pkg.sv | 32 +++
 rtl/lfsr32.sv | 36 +++
 rtl/alu_stim_gen.sv | 260 ++++++++++++++++++++++++++
 tb/tb_alu_stim_gen.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu1_pkg.sv
`default_nettype none
// ============================================================================
// alu1_pkg : command-space constants shared with the ALU1 datapath.
// Rev 1.0
// ============================================================================
package alu1_pkg;

    localparam int ALU1_CMD_WIDTH   = 3;
    localparam int ALU1_NR_COMMANDS = 6;

endpackage
`default_nettype wire

// File: rtl/alu_stim_pkg.sv
`default_nettype none
// ============================================================================
// alu_stim_pkg : state encoding, LFSR constants and corner codes for alu_stim_gen.
// Rev 1.0
// ============================================================================
package alu_stim_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GEN   = 2'd1,
        OFFER = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

    localparam logic [2:0] CORNER_ZERO = 3'b000;
    localparam logic [2:0] CORNER_ONES = 3'b111;

    // Galois right-shift step; the returned value is the generated word.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) begin
            n = n ^ LFSR_POLY;
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr32.sv
`default_nettype none
// ============================================================================
// lfsr32 : 32-bit Galois LFSR with load (zero maps to 1) and step enable.
// Rev 1.0
// ============================================================================
module lfsr32
    import alu_stim_pkg::*;
#(
    parameter logic [31:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_value,
    input  logic        step,
    output logic [31:0] state
);

    localparam logic [31:0] SAFE_SEED = (SEED == 32'h0) ? 32'h1 : SEED;

    logic [31:0] r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SAFE_SEED;
        end else if (load) begin
            r_state <= (load_value == 32'h0) ? 32'h1 : load_value;
        end else if (step) begin
            r_state <= lfsr_step(r_state);
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/alu_stim_gen.sv
`default_nettype none
// ============================================================================
// alu_stim_gen : seeded pseudo-random {cmd,in1,in2} source on a valid/ready port.
// Optional build macro: ALU_STIM_PREFETCH_EN (overlaps generation with offer).
// Rev 1.0
// ============================================================================
module alu_stim_gen
    import alu1_pkg::*;
    import alu_stim_pkg::*;
#(
    parameter int          WIDTH       = 64,
    parameter int          CMD_WIDTH   = ALU1_CMD_WIDTH,
    parameter int          NR_COMMANDS = ALU1_NR_COMMANDS,
    parameter int          CNT_W       = 16,
    parameter logic [31:0] SEED        = DEFAULT_SEED
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_txn,
    input  logic                 seed_load,
    input  logic [31:0]          seed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CMD_WIDTH-1:0] out_cmd,
    output logic [WIDTH-1:0]     out_in1,
    output logic [WIDTH-1:0]     out_in2,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     sent_count
);

    localparam int WORDS      = (WIDTH + 31) / 32;
    localparam int GEN_CYCLES = 2 + 2 * WORDS;
    localparam int GC_W       = $clog2(GEN_CYCLES);

    localparam logic [GC_W-1:0]  LAST_WORD = GC_W'(GEN_CYCLES - 1);
    localparam logic [GC_W-1:0]  GC_ONE    = GC_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t r_state;
    state_t w_state_next;

    logic [GC_W-1:0]      r_cnt;
    logic [CNT_W-1:0]     r_num_txn;
    logic [CNT_W-1:0]     r_sent;
    logic [31:0]          w_lfsr_state;
    logic [31:0]          w_word;

    // Build registers: the transaction being assembled word by word.
    logic [CMD_WIDTH-1:0] r_b_cmd,  w_b_cmd;
    logic [2:0]           r_b_sel1, w_b_sel1;
    logic [2:0]           r_b_sel2, w_b_sel2;
    logic [WORDS*32-1:0]  r_b_in1,  w_b_in1;
    logic [WORDS*32-1:0]  r_b_in2,  w_b_in2;

    logic [2:0]           w_src_sel1, w_src_sel2;
    logic [WORDS*32-1:0]  w_src_in1, w_src_in2;
    logic [WIDTH-1:0]     w_fin_in1, w_fin_in2;

    logic w_idle, w_start, w_hs, w_last;
    logic w_gen_en, w_gen_fin, w_refill;

    assign w_idle     = (r_state == IDLE) || (r_state == DONE);
    assign w_start    = start && w_idle;
    assign out_valid  = (r_state == OFFER);
    assign busy       = (r_state == GEN) || (r_state == OFFER);
    assign done       = (r_state == DONE);
    assign sent_count = r_sent;
    assign w_hs       = out_valid && out_ready;
    assign w_last     = w_hs && ((r_sent + CNT_ONE) == r_num_txn);
    assign w_word     = lfsr_step(w_lfsr_state);

    lfsr32 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .load       (seed_load && w_idle),
        .load_value (seed),
        .step       (w_gen_en),
        .state      (w_lfsr_state)
    );

`ifdef ALU_STIM_PREFETCH_EN
    logic                 r_staged;
    logic [CNT_W-1:0]     r_gen_left;
    logic [CMD_WIDTH-1:0] r_o_cmd;
    logic [WIDTH-1:0]     r_o_in1;
    logic [WIDTH-1:0]     r_o_in2;
    logic                 w_load_out;

    // Generation stops once num_txn transactions have been built, and stalls
    // while a finished transaction waits behind the one being offered.
    assign w_gen_en   = busy && (r_gen_left != '0) && !r_staged;
    assign w_refill   = r_staged || w_gen_fin;
    assign w_load_out = (w_gen_fin && ((r_state == GEN) || w_hs)) || (w_hs && r_staged);

    assign w_src_sel1 = w_b_sel1;
    assign w_src_sel2 = w_b_sel2;
    assign w_src_in1  = w_b_in1;
    assign w_src_in2  = w_b_in2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_staged   <= 1'b0;
            r_gen_left <= '0;
            r_o_cmd    <= '0;
            r_o_in1    <= '0;
            r_o_in2    <= '0;
        end else begin
            if (w_start) begin
                r_gen_left <= num_txn;
                r_staged   <= 1'b0;
            end else begin
                if (w_gen_fin) begin
                    r_gen_left <= r_gen_left - CNT_ONE;
                end
                if (w_gen_fin && !w_load_out) begin
                    r_staged <= 1'b1;
                end else if (w_load_out) begin
                    r_staged <= 1'b0;
                end
            end
            if (w_load_out) begin
                r_o_cmd <= w_b_cmd;
                r_o_in1 <= w_fin_in1;
                r_o_in2 <= w_fin_in2;
            end
        end
    end

    assign out_cmd = r_o_cmd;
    assign out_in1 = r_o_in1;
    assign out_in2 = r_o_in2;
`else
    assign w_gen_en   = (r_state == GEN);
    assign w_refill   = 1'b0;

    assign w_src_sel1 = r_b_sel1;
    assign w_src_sel2 = r_b_sel2;
    assign w_src_in1  = r_b_in1;
    assign w_src_in2  = r_b_in2;

    assign out_cmd = r_b_cmd;
    assign out_in1 = w_fin_in1;
    assign out_in2 = w_fin_in2;
`endif

    assign w_gen_fin = w_gen_en && (r_cnt == LAST_WORD);

    always_comb begin
        w_b_cmd  = r_b_cmd;
        w_b_sel1 = r_b_sel1;
        w_b_sel2 = r_b_sel2;
        w_b_in1  = r_b_in1;
        w_b_in2  = r_b_in2;
        if (w_gen_en) begin
            if (r_cnt == '0) begin
                w_b_cmd = CMD_WIDTH'(w_word % 32'(NR_COMMANDS));
            end
            if (r_cnt == GC_ONE) begin
                w_b_sel1 = w_word[2:0];
                w_b_sel2 = w_word[5:3];
            end
            for (int w = 0; w < WORDS; w++) begin
                if (r_cnt == GC_W'(2 + w)) begin
                    w_b_in1[w*32 +: 32] = w_word;
                end
                if (r_cnt == GC_W'(2 + WORDS + w)) begin
                    w_b_in2[w*32 +: 32] = w_word;
                end
            end
        end
    end

    always_comb begin
        w_fin_in1 = w_src_in1[WIDTH-1:0];
        if (w_src_sel1 == CORNER_ZERO) begin
            w_fin_in1 = '0;
        end else if (w_src_sel1 == CORNER_ONES) begin
            w_fin_in1 = '1;
        end
        w_fin_in2 = w_src_in2[WIDTH-1:0];
        if (w_src_sel2 == CORNER_ZERO) begin
            w_fin_in2 = '0;
        end else if (w_src_sel2 == CORNER_ONES) begin
            w_fin_in2 = '1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_next = (num_txn == '0) ? DONE : GEN;
                end
            end
            GEN: begin
                if (w_gen_fin) begin
                    w_state_next = OFFER;
                end
            end
            OFFER: begin
                if (w_hs) begin
                    if (w_last) begin
                        w_state_next = DONE;
                    end else if (w_refill) begin
                        w_state_next = OFFER;
                    end else begin
                        w_state_next = GEN;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_num_txn <= '0;
            r_sent    <= '0;
            r_b_cmd   <= '0;
            r_b_sel1  <= '0;
            r_b_sel2  <= '0;
            r_b_in1   <= '0;
            r_b_in2   <= '0;
        end else begin
            r_b_cmd  <= w_b_cmd;
            r_b_sel1 <= w_b_sel1;
            r_b_sel2 <= w_b_sel2;
            r_b_in1  <= w_b_in1;
            r_b_in2  <= w_b_in2;
            if (w_start) begin
                r_num_txn <= num_txn;
                r_sent    <= '0;
                r_cnt     <= '0;
            end else begin
                if (w_hs) begin
                    r_sent <= r_sent + CNT_ONE;
                end
                if (w_gen_en) begin
                    r_cnt <= w_gen_fin ? '0 : (r_cnt + GC_ONE);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_stim_gen.sv
`default_nettype none
// ============================================================================
// tb_alu_stim_gen : directed self-checking bench for alu_stim_gen (WIDTH=64).
// Rev 1.0
// ============================================================================
module tb_alu_stim_gen;
    import alu1_pkg::*;

    localparam int W    = 64;
    localparam int CW   = ALU1_CMD_WIDTH;
    localparam int NRC  = ALU1_NR_COMMANDS;
    localparam int CNTW = 16;
`ifdef ALU_STIM_PREFETCH_EN
    localparam int       PERIOD = 6;
    localparam bit       PF     = 1'b1;
`else
    localparam int       PERIOD = 7;
    localparam bit       PF     = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            seed_load = 1'b0;
    logic            out_ready = 1'b0;
    logic [CNTW-1:0] num_txn = '0;
    logic [31:0]     seed = '0;
    logic            out_valid, busy, done;
    logic [CNTW-1:0] sent_count;
    logic [CW-1:0]   out_cmd;
    logic [W-1:0]    out_in1, out_in2;

    int total = 0;
    int bad   = 0;

    logic [31:0]   m_st;
    logic [CW-1:0] e_cmd;
    logic [2:0]    e_c1, e_c2;
    logic [W-1:0]  e_in1, e_in2;

    always #5 clk = ~clk;

    alu_stim_gen #(
        .WIDTH (W),
        .CNT_W (CNTW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_txn    (num_txn),
        .seed_load  (seed_load),
        .seed       (seed),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_cmd    (out_cmd),
        .out_in1    (out_in1),
        .out_in2    (out_in2),
        .busy       (busy),
        .done       (done),
        .sent_count (sent_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] m_step(input logic [31:0] s);
        logic [31:0] n;
        n = {1'b0, s[31:1]};
        if (s[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    task automatic m_next();
        logic [31:0] w [6];
        for (int i = 0; i < 6; i++) begin
            m_st = m_step(m_st);
            w[i] = m_st;
        end
        e_cmd = CW'(w[0] % 32'(NRC));
        e_c1  = w[1][2:0];
        e_c2  = w[1][5:3];
        e_in1 = (e_c1 == 3'b000) ? '0 : (e_c1 == 3'b111) ? '1 : {w[3], w[2]};
        e_in2 = (e_c2 == 3'b000) ? '0 : (e_c2 == 3'b111) ? '1 : {w[5], w[4]};
    endtask

    task automatic wait_valid(input string tag, input int lim);
        int n = 0;
        while (!out_valid && n < lim) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, out_valid, 1);
    endtask

    task automatic chk_txn(input string tag);
        m_next();
        chk({tag, "_cmd"}, out_cmd, e_cmd);
        chk({tag, "_in1"}, out_in1, e_in1);
        chk({tag, "_in2"}, out_in2, e_in2);
    endtask

    task automatic start_run(input int n);
        num_txn = CNTW'(n);
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc, k, nz, no, ez, eo, tbad;

        // reset values
        repeat (3) tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sent", sent_count, 0);
        chk("rst_cmd", out_cmd, 0);
        chk("rst_in1", out_in1, 0);
        chk("rst_in2", out_in2, 0);
        rst = 1'b0;
        repeat (2) tick();
        chk("idle_valid", out_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_lfsr", dut.u_lfsr.state, 32'h1);

        // zero-length run
        start_run(0);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_sent", sent_count, 0);
        k = 0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid) k++;
            tick();
        end
        chk("zero_novalid", k, 0);
        chk("zero_done_hold", done, 1);

        // three transactions with out_ready held high
        m_st = 32'h1;
        out_ready = 1'b1;
        start_run(3);
        cyc = 1;
        k = 0;
        while (!done && cyc < 40) begin
            if (out_valid && out_ready) begin
                chk("run3_hs_cycle", cyc, 7 + k * PERIOD);
                chk("run3_cmd_range", out_cmd < CW'(NRC), 1);
                chk_txn("run3");
                if (k == 0) begin
                    chk("hand_cmd", out_cmd, 1);
                    chk("hand_in1", out_in1, 64'hB02C_0003_6018_0001);
                    chk("hand_in2", out_in2, 0);
                end
                k++;
            end
            tick();
            cyc++;
        end
        chk("run3_count", k, 3);
        chk("run3_done_cycle", cyc, 7 + 2 * PERIOD + 1);
        chk("run3_sent", sent_count, 3);

        // backpressure: hold out_ready low while the first offer waits
        out_ready = 1'b0;
        start_run(2);
        wait_valid("bp", 20);
        m_next();
        for (int i = 0; i < 8; i++) begin
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_cmd", out_cmd, e_cmd);
            chk("bp_hold_in1", out_in1, e_in1);
            chk("bp_hold_in2", out_in2, e_in2);
            chk("bp_hold_sent", sent_count, 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_sent1", sent_count, 1);
        chk("bp_refill_valid", out_valid, PF);
        wait_valid("bp2", 20);
        chk_txn("bp2");
        tick();
        chk("bp_sent2", sent_count, 2);
        chk("bp_done", done, 1);

        // seed 0 loads as 1
        seed = 32'h0;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        start_run(1);
        wait_valid("seed0", 20);
        chk("seed0_cmd", out_cmd, 1);
        chk("seed0_in1", out_in1, 64'hB02C_0003_6018_0001);
        chk("seed0_in2", out_in2, 0);
        tick();

        // start together with seed_load
        seed = 32'hDEAD_BEEF;
        seed_load = 1'b1;
        start_run(1);
        seed_load = 1'b0;
        wait_valid("seedx", 20);
        chk("seedx_cmd_hand", out_cmd, 0);
        m_st = 32'hDEAD_BEEF;
        chk_txn("seedx");
        tick();

        // reset during generation of the second transaction
        start_run(3);
        k = 0;
        while (sent_count != 1 && k < 30) begin
            tick();
            k++;
        end
        chk("mid_sent1", sent_count, 1);
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        chk("mid_valid", out_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_sent", sent_count, 0);
        chk("mid_lfsr", dut.u_lfsr.state, 32'h1);
        tick();
        rst = 1'b0;
        tick();
        m_st = 32'h1;
        start_run(2);
        wait_valid("post", 20);
        chk("post_hand_in1", out_in1, 64'hB02C_0003_6018_0001);
        chk_txn("post0");
        tick();
        wait_valid("post1", 20);
        chk_txn("post1");
        tick();

        // long run: corner occurrences against the model
        nz = 0; no = 0; ez = 0; eo = 0; tbad = 0; k = 0; cyc = 0;
        start_run(600);
        while (!done && cyc < 6000) begin
            if (out_valid) begin
                m_next();
                if (out_cmd !== e_cmd || out_in1 !== e_in1 || out_in2 !== e_in2) tbad++;
                nz += int'(out_in1 == '0) + int'(out_in2 == '0);
                no += int'(out_in1 == '1) + int'(out_in2 == '1);
                ez += int'(e_c1 == 3'b000) + int'(e_c2 == 3'b000);
                eo += int'(e_c1 == 3'b111) + int'(e_c2 == 3'b111);
                k++;
            end
            tick();
            cyc++;
        end
        chk("hist_count", k, 600);
        chk("hist_txn_bad", tbad, 0);
        chk("hist_zero", nz, ez);
        chk("hist_ones", no, eo);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
